// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path: index/word types, FSM states and source ids.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {ST_CLEAR, ST_RUN} wb_state_t;
  typedef enum logic {SRC_ALU, SRC_LD} wb_src_t;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// 2-input round-robin arbiter; grant is combinational, last_gnt moves only on a completed transfer.
module wb_rr_arb
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_alu,
  input  logic       req_ld,
  input  logic       en,
  input  logic       xfer_done,
  output logic [1:0] gnt        // [0] = ALU, [1] = LD
);

  wb_src_t last_gnt_q, last_gnt_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req_alu && req_ld) begin
        gnt = (last_gnt_q == SRC_LD) ? 2'b01 : 2'b10;
      end else begin
        gnt = {req_ld, req_alu};
      end
    end
  end

  // Kept separate from the grant logic: xfer_done is derived from gnt outside this module.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (xfer_done) begin
      last_gnt_d = gnt[1] ? SRC_LD : SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= SRC_LD;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller sharing reg_file's single write port between ALU and load unit (RR, x0 dropped).
// Write request is registered (1 cycle after acceptance); REGFILE_CLEAR_EN adds a post-reset clear of all registers.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy
);

  wb_state_t         state_q, state_d;
  logic              rf_en_q, rf_en_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              port_open;
  logic [1:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_writes;

  // rst_n gates readiness directly so nothing is accepted while reset is held.
  assign port_open = rst_n && (state_q == ST_RUN);

  wb_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_alu   (alu_valid),
    .req_ld    (ld_valid),
    .en        (port_open),
    .xfer_done (xfer),
    .gnt       (gnt)
  );

  assign alu_ready  = gnt[0];
  assign ld_ready   = gnt[1];
  assign xfer       = (alu_valid && alu_ready) || (ld_valid && ld_ready);
  assign sel_rd     = ld_ready ? ld_rd : alu_rd;
  assign sel_data   = ld_ready ? ld_data : alu_data;
  assign sel_writes = (sel_rd != '0) && (int'(sel_rd) < NUM_REGS);

`ifdef REGFILE_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rf_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
`ifdef REGFILE_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef REGFILE_CLEAR_EN
        rf_en_d   = 1'b1;
        wr_reg_d  = clr_cnt_q;
        wr_data_d = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (int'(clr_cnt_q) == NUM_REGS - 1) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: begin
        if (xfer && sel_writes) begin
          rf_en_d   = 1'b1;
          wr_reg_d  = sel_rd;
          wr_data_d = sel_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef REGFILE_CLEAR_EN
      state_q   <= ST_CLEAR;
`else
      state_q   <= ST_RUN;
`endif
      rf_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rf_en_q   <= rf_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_en         = rf_en_q;
  assign rf_write_reg  = wr_reg_q;
  assign rf_write_data = wr_data_q;

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for `reg_file`: owns its single write port (`en`, `write_reg`, `write_data`) and shares it between the ALU result path and the load unit. Arbitrates round-robin with valid/ready handshakes, suppresses writes to x0, and drives a registered write request into `reg_file`. Optionally sequences a post-reset clear of all registers before opening the port.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width
- `NUM_REGS`, 32, register count (= 2**ADDR_W)

Ports:
- `clk`  in  1  rising-edge clock, shared with `reg_file`
- `rst_n`  in  1  reset; asynchronous, active-low
- `alu_valid`  in  1  ALU write-back request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `ld_valid`  in  1  load write-back request
- `ld_ready`  out  1  load request accepted this cycle
- `ld_rd`  in  ADDR_W  load destination register
- `ld_data`  in  DATA_W  load data
- `rf_en`  out  1  to `reg_file.en`
- `rf_write_reg`  out  ADDR_W  to `reg_file.write_reg`
- `rf_write_data`  out  DATA_W  to `reg_file.write_data`
- `busy`  out  1  clear sequence in progress; port closed

## Operation
- States: `ST_CLEAR`, `ST_RUN`. Without the clear feature, only `ST_RUN` exists.
- Handshake: transfer when `valid && ready` at a rising edge.
  - Requesters hold `valid`, `rd` and `data` stable until accepted.
  - `valid` must not depend on `ready`; `ready` may depend on both `valid`s.
- Readiness:
  - Both `ready`s are 0 in `ST_CLEAR` and while `rst_n` is low.
  - In `ST_RUN`, at most one `ready` is 1 per cycle.
- Arbitration (`ST_RUN`):
  - One requester valid: it is granted.
  - Both valid: grant goes to the requester not granted last. `last_gnt` resets to LD, so ALU wins the first tie.
  - `last_gnt` updates only on a completed transfer.
- x0: a transfer with `rd == 0` completes its handshake and updates `last_gnt`, but `rf_en` stays 0 the next cycle.
- Output register: an accepted transfer with `rd != 0` loads `rf_write_reg`/`rf_write_data` and sets `rf_en = 1` for exactly one cycle. With no transfer, `rf_en = 0`; `rf_write_reg`/`rf_write_data` hold their previous values.
- Same-`rd` collision: both requesters target one register. The loser is accepted on a later cycle, so its value is the final contents.
- Throughput: one write per cycle; sustained alternation under contention.

## Timing
- Transfer at edge N → `rf_en` high during cycle N..N+1 → `reg_file` captures at edge N+1. Read ports show the new value after edge N+1 (2-edge latency from acceptance).
- `ready` is combinational from `valid`s, `state`, `last_gnt`; no other combinational paths to outputs.
- Reset values:
  - `rf_en = 0`, `rf_write_reg = 0`, `rf_write_data = 0`
  - `alu_ready = ld_ready = 0`
  - `last_gnt = LD`
  - `busy = 1` with the clear feature, 0 without
- Reset mid-operation: the in-flight `rf_en` pulse is cancelled immediately; no partial write is issued.

## Configuration
- Macro: `REGFILE_CLEAR_EN`.
- Defined:
  - Reset enters `ST_CLEAR` with `clr_cnt = 0`.
  - Each cycle drives `rf_en = 1`, `rf_write_reg = clr_cnt`, `rf_write_data = 0`; `clr_cnt` increments.
  - After index `NUM_REGS-1` (32 cycles), moves to `ST_RUN` and `busy` falls.
  - The first `ready` can be asserted in the cycle after `busy` falls.
  - Reset during clear restarts at index 0.
- Undefined: reset enters `ST_RUN`; `busy` tied 0; no `clr_cnt` logic.

## Structure
- Package `regfile_pkg`:
  - `reg_idx_t` (ADDR_W bits), `word_t` (DATA_W bits)
  - `NUM_REGS`
  - `wb_state_t` {`ST_CLEAR`, `ST_RUN`}
  - `wb_src_t` {`SRC_ALU`, `SRC_LD`}
- Sub-module `wb_rr_arb`: 2-input round-robin arbiter holding `last_gnt`.
  - Inputs: two requests, enable, transfer-done.
  - Outputs: one-hot grant.
- `regfile_wb_ctrl` keeps the FSM, clear counter, x0 filter and output register.

## Test plan
- Single ALU write: `alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF` → `alu_ready=1` same cycle; `rf_en=1, rf_write_reg=5` next cycle; `read_data1` at `read_reg1=5` = `DEADBEEF` after the following edge.
- Contention: both valid for 4 cycles, `alu_rd=1`, `ld_rd=2` → grants ALU, LD, ALU, LD; `rf_write_reg` sequence 1,2,1,2.
- x0 drop: `ld_valid=1, ld_rd=0, ld_data=32'hFFFFFFFF` → `ld_ready=1`, `rf_en` stays 0, register 0 reads 0.
- Same-rd collision: ALU `rd=7 data=1`, LD `rd=7 data=2` both valid from reset → ALU accepted first, LD second; register 7 ends at 2.
- `REGFILE_CLEAR_EN`:
  - After reset: `busy=1` for 32 cycles with `rf_write_reg` 0..31, `rf_write_data=0`, both `ready`s 0; all registers read 0 afterwards.
  - `rst_n` pulsed low at cycle 10: clear restarts at index 0.
- Reset during write: assert `rst_n=0` while `rf_en=1` → `rf_en` drops immediately; target register unchanged.
